// File: rtl/controle_lampada_if.sv
// Lamp controller bus: the button and shutdown pulse go in, lamp/mode/enable come out.
interface controle_lampada_if;
   logic push_button;  // raw button, 1 = pressed
   logic C;            // one-cycle auto-shutdown pulse from the timer
   logic L;            // lamp drive, 1 = on
   logic enable;       // timer enable, L & auto_mode
   logic auto_mode;    // 1 = automatic shutdown active

   // Environment side: drives the button and the timer pulse.
   modport master (
      output push_button,
      output C,
      input  L,
      input  enable,
      input  auto_mode
   );

   // Controller side.
   modport slave (
      input  push_button,
      input  C,
      output L,
      output enable,
      output auto_mode
   );
endinterface

// File: rtl/controle_lampada.sv
// Lamp-side controller: debounces the button, tells short presses (toggle lamp)
// from long presses (toggle automatic mode), and applies the timer's
// auto-shutdown pulse. Every output comes straight from a flop.
module controle_lampada #(
   parameter int DEBOUNCE_T   = 100,
   parameter int LONG_PRESS_T = 3000
) (
   input  logic                  clk,
   input  logic                  rst,
   controle_lampada_if.slave     bus
);

   localparam logic [15:0] DEB_C  = 16'(DEBOUNCE_T);
   localparam logic [15:0] LONG_C = 16'(LONG_PRESS_T);

   typedef enum logic {
      SOLTO       = 1'b0,
      PRESSIONADO = 1'b1
   } press_state_t;

   press_state_t state_q, state_d;
   logic [15:0]  tp_q, tp_d;
   logic         l_q, l_d;
   logic         auto_q, auto_d;
   logic         enable_q, enable_d;
   logic         release_s;
   logic         short_s;
   logic         long_s;
   logic         c_eff_s;

   // Classify the release and work out the next lamp, mode and counter values.
   always_comb begin
      release_s = (state_q == PRESSIONADO) && !bus.push_button;
      long_s    = release_s && (tp_q >= LONG_C);
      short_s   = release_s && (tp_q >= DEB_C) && (tp_q < LONG_C);
      // The timer pulse only matters while the lamp is on in automatic mode;
      // otherwise it is dropped and never remembered.
      c_eff_s   = bus.C && auto_q && l_q;

      // Counter saturates at the long-press threshold so a held button never wraps.
      if (bus.push_button) begin
         if (tp_q >= LONG_C) begin
            tp_d = LONG_C;
         end else begin
            tp_d = tp_q + 16'd1;
         end
      end else begin
         tp_d = 16'd0;
      end

      case (state_q)
         SOLTO: begin
            if (bus.push_button) begin
               state_d = PRESSIONADO;
            end else begin
               state_d = SOLTO;
            end
         end
         PRESSIONADO: begin
            if (!bus.push_button) begin
               state_d = SOLTO;
            end else begin
               state_d = PRESSIONADO;
            end
         end
         default: state_d = SOLTO;
      endcase

      if (short_s) begin
         l_d = ~l_q;
      end else begin
         l_d = l_q;
      end

      if (long_s) begin
         auto_d = ~auto_q;
      end else begin
         auto_d = auto_q;
      end

      // Shutdown wins over a short-press toggle on the same edge.
      if (c_eff_s) begin
         l_d = 1'b0;
      end else begin
         l_d = l_d;
      end

      enable_d = l_d & auto_d;
   end

   // Press FSM, counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= SOLTO;
         tp_q     <= 16'd0;
         l_q      <= 1'b0;
         auto_q   <= 1'b1;
         enable_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tp_q     <= tp_d;
         l_q      <= l_d;
         auto_q   <= auto_d;
         enable_q <= enable_d;
      end
   end

   assign bus.L         = l_q;
   assign bus.auto_mode = auto_q;
   assign bus.enable    = enable_q;

endmodule

// File: tb/tb_controle_lampada.sv
// Directed bench for controle_lampada with DEBOUNCE_T=4, LONG_PRESS_T=20.
// Expected {L, auto_mode, enable} triples are queued when stimulus is driven
// and popped when the outputs are sampled.
module tb_controle_lampada;

   localparam int DEB  = 4;
   localparam int LONG = 20;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   logic m_l;
   logic m_a;
   logic [2:0] exp_q[$];

   controle_lampada_if bus ();

   controle_lampada #(
      .DEBOUNCE_T   (DEB),
      .LONG_PRESS_T (LONG)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Queue the current model state as the next expected output.
   task automatic expect_model();
      exp_q.push_back({m_l, m_a, m_l & m_a});
   endtask

   // Pop the oldest expectation and compare it with the outputs.
   task automatic check(input string tag);
      logic [2:0] exp_v;
      logic [2:0] act_v;
      act_v = {bus.L, bus.auto_mode, bus.enable};
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s: scoreboard empty, L/auto/en got %b", tag, act_v);
      end else begin
         exp_v = exp_q.pop_front();
         assert (act_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: L/auto/en got %b want %b", tag, act_v, exp_v);
         end
      end
   endtask

   // One clock: drive at the falling edge, return just after the rising edge.
   task automatic cyc(input logic pb, input logic c);
      @(negedge clk);
      bus.push_button = pb;
      bus.C           = c;
      @(posedge clk);
      #1;
   endtask

   // Hold the button for n edges, release (optionally with C on the release edge).
   task automatic press(input int n, input logic c_rel, input string tag);
      logic old_l;
      logic old_a;
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b0);
      end
      // Nothing may change while the button is still held.
      expect_model();
      check({tag, "_held"});
      old_l = m_l;
      old_a = m_a;
      if (n >= LONG) begin
         m_a = ~old_a;
      end else if (n >= DEB) begin
         m_l = ~old_l;
      end
      if (c_rel && old_a && old_l) begin
         m_l = 1'b0;
      end
      expect_model();
      cyc(1'b0, c_rel);
      check(tag);
      cyc(1'b0, 1'b0);
   endtask

   // One-cycle timer pulse with the button released.
   task automatic cpulse(input string tag);
      if (m_a && m_l) begin
         m_l = 1'b0;
      end
      expect_model();
      cyc(1'b0, 1'b1);
      check(tag);
      cyc(1'b0, 1'b0);
   endtask

   initial begin
      n_tests         = 0;
      n_fail          = 0;
      rst             = 1'b1;
      bus.push_button = 1'b0;
      bus.C           = 1'b0;
      m_l             = 1'b0;
      m_a             = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      expect_model();
      check("reset");

      // Bounce, then short presses.
      press(3, 1'b0, "short3_bounce");
      press(5, 1'b0, "short5_on");
      press(5, 1'b0, "short5_off");

      // Timer shutdown, and a pulse with the lamp off is forgotten.
      press(5, 1'b0, "lamp_on");
      cpulse("c_off");
      cpulse("c_ignored_l0");
      press(5, 1'b0, "lamp_on_after_c");

      // Long press into manual mode; C has no effect there.
      press(25, 1'b0, "long_manual");
      cpulse("c_ignored_manual");
      press(25, 1'b0, "long_auto");

      // C on the release edge of a short and of a long press.
      press(6, 1'b1, "short_with_c");
      press(5, 1'b0, "lamp_on2");
      press(25, 1'b1, "long_with_c");
      press(25, 1'b0, "long_back_auto");

      // Reset in the middle of a press.
      press(5, 1'b0, "lamp_on3");
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b0);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      m_l = 1'b0;
      m_a = 1'b1;
      expect_model();
      check("async_reset");
      @(negedge clk);
      rst = 1'b0;
      press(2, 1'b0, "post_reset_release");

      // Bounce train 1,0,1,1,0.
      expect_model();
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      check("bounce_train");

      // Threshold boundaries.
      press(DEB, 1'b0, "exact_debounce");
      press(LONG - 1, 1'b0, "just_below_long");
      press(LONG, 1'b0, "exact_long");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
